// File: rtl/stack_xfer_sequencer.sv
// stack_xfer_sequencer: M-cycle sequencer for PUSH/POP of a multi-byte register group
module stack_xfer_sequencer #(
    parameter int BYTES   = 2,
    parameter int T_PER_M = 4,
    parameter int BIDX_W  = (BYTES > 1) ? $clog2(BYTES) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              op,
    input  logic [3:0]        p,
    input  logic              mem_ready,
    output logic              busy,
    output logic              done,
    output logic [3:0]        reg_sel,
    output logic [BYTES-1:0]  byte_sel,
    output logic [BIDX_W-1:0] byte_idx,
    output logic              address_out,
    output logic              bus_out,
    output logic              bus_load,
    output logic              sp_dec,
    output logic              sp_inc,
    output logic              ir_fetch
);
    localparam int TW = $clog2(T_PER_M);

    typedef enum logic [1:0] {IDLE, PRE, DATA, FETCH} state_t;

    state_t            state;
    logic [TW-1:0]     t;
    logic [BIDX_W-1:0] bidx;
    logic              pop;
    logic [3:0]        grp;
    logic              last_t;
    logic              last_byte;
    logic              accept;
    logic              is_data;
    logic              fire;

    assign last_t    = t == TW'(T_PER_M - 1);
    assign last_byte = pop ? bidx == BIDX_W'(BYTES - 1) : bidx == '0;
    assign accept    = start && $onehot(p) && (state == IDLE || (state == FETCH && last_t));
    assign is_data   = state == DATA;
    // a data M-cycle only completes (and strobes) on its last T-step with memory ready
    assign fire      = is_data && last_t && mem_ready;

    // sequence state: M-cycle phase, T-step, byte counter and latched request
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            t     <= '0;
            bidx  <= '0;
            pop   <= 1'b0;
            grp   <= '0;
        end else if (accept) begin
            state <= op ? DATA : PRE;
            t     <= '0;
            bidx  <= op ? '0 : BIDX_W'(BYTES - 1);
            pop   <= op;
            grp   <= p;
        end else if (state == FETCH && last_t) begin
            state <= IDLE;
            t     <= '0;
        end else if (state == PRE) begin
            t     <= last_t ? '0 : t + 1'b1;
            state <= last_t ? DATA : PRE;
        end else if (is_data) begin
            if (!last_t) begin
                t <= t + 1'b1;
            end else if (mem_ready) begin
                t     <= '0;
                state <= last_byte ? FETCH : DATA;
                bidx  <= last_byte ? bidx : (pop ? bidx + 1'b1 : bidx - 1'b1);
            end
        end else if (state == FETCH) begin
            t <= t + 1'b1;
        end
    end

    // control outputs decoded from the sequence state; strobes gated by memory ready
    always_comb begin
        busy        = state != IDLE;
        done        = state == FETCH && last_t;
        reg_sel     = busy ? grp : '0;
        byte_sel    = is_data ? BYTES'(1) << bidx : '0;
        byte_idx    = is_data ? bidx : '0;
        address_out = is_data;
        bus_out     = is_data && !pop && t != '0;
        bus_load    = fire && pop;
        sp_inc      = fire && pop;
        sp_dec      = (state == PRE && last_t) || (fire && !pop && bidx != '0);
        ir_fetch    = state == FETCH;
    end
endmodule

// File: tb/tb_stack_xfer_sequencer.sv
// tb_stack_xfer_sequencer: directed and random PUSH/POP sequences checked per clock against a trace model
module tb_stack_xfer_sequencer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       op = 1'b0;
    logic [3:0] p = 4'b0;
    logic       mem_ready = 1'b1;
    logic       sel = 1'b0;
    logic       start_a, start_b;

    logic       a_busy, a_done, a_addr, a_bo, a_bl, a_dec, a_inc, a_irf;
    logic [3:0] a_reg;
    logic [1:0] a_bsel;
    logic [0:0] a_bidx;
    logic       b_busy, b_done, b_addr, b_bo, b_bl, b_dec, b_inc, b_irf;
    logic [3:0] b_reg;
    logic [3:0] b_bsel;
    logic [1:0] b_bidx;

    int cmp = 0;
    int err = 0;
    int wv[4];
    logic [23:0] exp_q[$];
    logic        rdy_q[$];

    assign start_a = start && !sel;
    assign start_b = start && sel;

    always #5 clk = ~clk;

    stack_xfer_sequencer dut (
        .clk(clk), .rst(rst), .start(start_a), .op(op), .p(p), .mem_ready(mem_ready),
        .busy(a_busy), .done(a_done), .reg_sel(a_reg), .byte_sel(a_bsel), .byte_idx(a_bidx),
        .address_out(a_addr), .bus_out(a_bo), .bus_load(a_bl), .sp_dec(a_dec), .sp_inc(a_inc),
        .ir_fetch(a_irf)
    );

    stack_xfer_sequencer #(.BYTES(4), .T_PER_M(2)) dut4 (
        .clk(clk), .rst(rst), .start(start_b), .op(op), .p(p), .mem_ready(mem_ready),
        .busy(b_busy), .done(b_done), .reg_sel(b_reg), .byte_sel(b_bsel), .byte_idx(b_bidx),
        .address_out(b_addr), .bus_out(b_bo), .bus_load(b_bl), .sp_dec(b_dec), .sp_inc(b_inc),
        .ir_fetch(b_irf)
    );

    // {busy, done, reg_sel[3:0], byte_sel[7:0], byte_idx[3:0], addr, bus_out, bus_load, sp_dec, sp_inc, ir_fetch}
    function automatic logic [23:0] obs();
        if (sel)
            return {b_busy, b_done, b_reg, 4'b0, b_bsel, 2'b0, b_bidx, b_addr, b_bo, b_bl, b_dec, b_inc, b_irf};
        return {a_busy, a_done, a_reg, 6'b0, a_bsel, 3'b0, a_bidx, a_addr, a_bo, a_bl, a_dec, a_inc, a_irf};
    endfunction

    // expected outputs for one clock: ph 0=PRE 1=DATA 2=FETCH, k=byte, t=T-step, fire=strobe clock
    function automatic logic [23:0] ent(int ph, int k, int t, int tpm, bit fire, bit popx, logic [3:0] px);
        bit lt = (t == tpm - 1);
        bit d = (ph == 1);
        logic [7:0] bs = d ? (8'd1 << k) : 8'd0;
        logic [3:0] bi = d ? 4'(k) : 4'd0;
        return {1'b1, (ph == 2) && lt, px, bs, bi, d, d && !popx && t > 0, d && popx && fire,
                (ph == 0 && lt) || (d && !popx && fire && k > 0), d && popx && fire, ph == 2};
    endfunction

    task automatic chk(string tag, int idx, logic [31:0] got, logic [31:0] expv);
        cmp++;
        assert (got === expv) else begin
            err++;
            $error("FAIL %s[%0d] observed %h expected %h", tag, idx, got, expv);
        end
    endtask

    // per-clock expected trace and ready pattern for one sequence
    task automatic build(int nb, int tpm, bit popx, logic [3:0] px);
        exp_q.delete();
        rdy_q.delete();
        if (!popx)
            for (int t = 0; t < tpm; t++) begin
                exp_q.push_back(ent(0, 0, t, tpm, 0, popx, px));
                rdy_q.push_back(1'($urandom));
            end
        for (int j = 0; j < nb; j++) begin
            int k = popx ? j : nb - 1 - j;
            for (int t = 0; t < tpm - 1; t++) begin
                exp_q.push_back(ent(1, k, t, tpm, 0, popx, px));
                rdy_q.push_back(1'($urandom));
            end
            for (int w = 0; w < wv[j]; w++) begin
                exp_q.push_back(ent(1, k, tpm - 1, tpm, 0, popx, px));
                rdy_q.push_back(1'b0);
            end
            exp_q.push_back(ent(1, k, tpm - 1, tpm, 1, popx, px));
            rdy_q.push_back(1'b1);
        end
        for (int t = 0; t < tpm; t++) begin
            exp_q.push_back(ent(2, 0, t, tpm, 0, popx, px));
            rdy_q.push_back(1'($urandom));
        end
    endtask

    task automatic kick(bit o, logic [3:0] g);
        @(posedge clk);
        #1;
        start = 1'b1;
        op = o;
        p = g;
    endtask

    // caller has already raised start for the current cycle
    task automatic run(string tag, int nb, int tpm, bit popx, logic [3:0] px, bit chain, bit nop,
                       logic [3:0] np, int exp_done);
        int done_at = 0;
        int net = 0;
        build(nb, tpm, popx, px);
        for (int i = 0; i < exp_q.size(); i++) begin
            logic [23:0] o;
            bit last = (i == exp_q.size() - 1);
            @(posedge clk);
            #1;
            start = chain && last;
            op = (chain && last) ? nop : 1'($urandom);
            p = (chain && last) ? np : 4'($urandom);
            mem_ready = rdy_q[i];
            @(negedge clk);
            o = obs();
            chk(tag, i + 1, 32'(o), 32'(exp_q[i]));
            if (o[22] && done_at == 0) done_at = i + 1;
            net += int'(o[1]) - int'(o[2]);
        end
        chk({tag, "_done_clk"}, 0, 32'(done_at), 32'(exp_done));
        chk({tag, "_sp_net"}, 0, 32'(net), 32'(popx ? nb : -nb));
    endtask

    task automatic idle_chk(string tag);
        @(posedge clk);
        #1;
        start = 1'b0;
        mem_ready = 1'($urandom);
        @(negedge clk);
        chk(tag, 0, 32'(obs()), 32'd0);
    endtask

    initial begin
        int ndec;
        logic [23:0] acc;
        bit started;
        bit cop;
        logic [3:0] cp;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_a", 0, 32'(obs()), 32'd0);
        sel = 1'b1;
        #1;
        chk("reset_b", 0, 32'(obs()), 32'd0);
        sel = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;

        wv = '{0, 0, 0, 0};
        kick(1'b0, 4'b0001);
        run("push_bc", 2, 4, 1'b0, 4'b0001, 1'b0, 1'b0, 4'b0, 16);
        idle_chk("push_bc_idle");

        wv = '{3, 0, 0, 0};
        kick(1'b1, 4'b0100);
        run("pop_hl_wait", 2, 4, 1'b1, 4'b0100, 1'b0, 1'b0, 4'b0, 15);
        idle_chk("pop_hl_idle");

        kick(1'b0, 4'b0001);
        ndec = 0;
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            mem_ready = 1'b1;
            @(negedge clk);
            ndec += int'(a_dec);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("abort_outputs", 6, 32'(obs()), 32'd0);
        acc = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            acc |= obs();
            ndec += int'(a_dec);
        end
        chk("abort_sp_dec", 0, 32'(ndec), 32'd1);
        chk("abort_quiet", 0, 32'(acc), 32'd0);

        kick(1'($urandom), 4'b0110);
        @(negedge clk);
        acc = obs();
        kick(1'($urandom), 4'b0000);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            acc |= obs();
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        chk("bad_group", 0, 32'(acc), 32'd0);

        wv = '{0, 0, 0, 0};
        kick(1'b0, 4'b0010);
        run("b2b_push_de", 2, 4, 1'b0, 4'b0010, 1'b1, 1'b1, 4'b1000, 16);
        run("b2b_pop_af", 2, 4, 1'b1, 4'b1000, 1'b0, 1'b0, 4'b0, 12);
        idle_chk("b2b_idle");

        sel = 1'b1;
        kick(1'b0, 4'b0001);
        run("push4_t2", 4, 2, 1'b0, 4'b0001, 1'b0, 1'b0, 4'b0, 12);
        idle_chk("push4_idle");

        started = 1'b0;
        cop = 1'b0;
        cp = 4'b0001;
        for (int s = 0; s < 30; s++) begin
            int nb, tpm, sum;
            bit chain, nop;
            logic [3:0] np;
            if (!started) begin
                sel = 1'($urandom);
                cop = 1'($urandom);
                cp = 4'd1 << $urandom_range(0, 3);
                kick(cop, cp);
            end
            nb = sel ? 4 : 2;
            tpm = sel ? 2 : 4;
            sum = 0;
            for (int j = 0; j < 4; j++) begin
                wv[j] = $urandom_range(0, 3);
                if (j < nb) sum += wv[j];
            end
            chain = (s < 29) && ($urandom_range(0, 2) == 0);
            nop = 1'($urandom);
            np = 4'd1 << $urandom_range(0, 3);
            run("rand", nb, tpm, cop, cp, chain, nop, np, (nb + (cop ? 1 : 2)) * tpm + sum);
            if (chain) begin
                cop = nop;
                cp = np;
            end else begin
                idle_chk("rand_idle");
            end
            started = chain;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
        $finish;
    end
endmodule
